fetch_unit: RTL and testbench

Instruction fetch stage of the single-issue RV32I core. It drives the instruction-memory request/response interface and holds fetched words in a 2-entry buffer. It presents `{pc, instr}` to decode over a valid/ready handshake; decode's `instr` feeds `imm_gen` and the control decoder. A redirect from execute (branch/jump target computed from the generated immediate) flushes the stage and discards in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_sync_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// XLEN         : architectural register / address width.
// RESET_VECTOR : default first fetch address after reset.
// NOP_INSTR    : canonical RV32I NOP (addi x0, x0, 0), used by decode.
// fetch_entry_t: one output-buffer record {pc, instr}.
package fetch_unit_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO (the fetch stage's sync_fifo).
// Parameters: WIDTH (entry width), DEPTH (entries, power of two).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_push_data at the tail
//   i_pop        : drop the head entry (ignored when empty)
//   i_flush      : discard all entries; wins over push and pop
//   o_count      : number of stored entries
//   o_head       : head entry, or 0 when empty
module fetch_unit_sync_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the RV32I core.
// Issues word-aligned fetches, tracks the PCs of outstanding requests,
// buffers returned words and hands {pc, instr} to decode. A redirect
// flushes everything and discards responses still in flight.
// Parameters: RESET_PC (first fetch address), DEPTH (2 or 4; bound on
//             outstanding requests plus buffered words).
// Ports:
//   clk, rst                         : clock, async active-high reset
//   imem_req_valid/ready/addr        : instruction memory request
//   imem_rsp_valid/data              : instruction memory response
//   out_valid/ready, out_instr/pc    : handshake towards decode
//   redirect_valid, redirect_pc      : control-flow redirect from execute
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]  r_pc;
    // Successive redirects can stack stale responses beyond DEPTH, so the
    // drop counter is sized generously rather than to DEPTH.
    logic [7:0]   r_drop_cnt;

    logic [CW-1:0] w_pend_cnt;
    logic [CW-1:0] w_buf_cnt;
    logic [31:0]   w_pend_head;
    fetch_entry_t  w_buf_in;
    fetch_entry_t  w_buf_head;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_out_fire;

    // Requests are gated by rst directly so they drop the moment reset rises.
    assign imem_req_valid = !rst && !redirect_valid &&
                            ((32'(w_pend_cnt) + 32'(w_buf_cnt)) < 32'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_keep = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

    assign out_valid  = (w_buf_cnt != '0) && !redirect_valid;
    assign out_instr  = w_buf_head.instr;
    assign out_pc     = w_buf_head.pc;
    assign w_out_fire = out_valid && out_ready;

    assign w_buf_in = '{pc: w_pend_head, instr: imem_rsp_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_pc       <= word_align(redirect_pc);
            // Everything still outstanding becomes stale; a response landing
            // in this very cycle is already consumed by the drop.
            r_drop_cnt <= r_drop_cnt + 8'(w_pend_cnt) - 8'(imem_rsp_valid);
        end else begin
            if (w_req_fire) r_pc <= r_pc + 32'd4;
            if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 8'd1;
        end
    end

    // PCs of accepted, unanswered requests, oldest first.
    fetch_unit_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_req_fire),
        .i_push_data (r_pc),
        .i_pop       (w_rsp_keep),
        .i_flush     (redirect_valid),
        .o_count     (w_pend_cnt),
        .o_head      (w_pend_head)
    );

    // Fetched {pc, instr} entries waiting for decode.
    fetch_unit_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_obuf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_rsp_keep),
        .i_push_data (w_buf_in),
        .i_pop       (w_out_fire),
        .i_flush     (redirect_valid),
        .o_count     (w_buf_cnt),
        .o_head      (w_buf_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Second instance: DEPTH=2 with a reset vector close to the top of memory.
    logic        req2_valid, rsp2_valid, out2_valid;
    logic [31:0] req2_addr, rsp2_data, out2_instr, out2_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req2_valid), .imem_req_ready(1'b1),
        .imem_req_addr(req2_addr),
        .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
        .out_valid(out2_valid), .out_ready(1'b1),
        .out_instr(out2_instr), .out_pc(out2_pc),
        .redirect_valid(1'b0), .redirect_pc(32'h0)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // ---------------- memory model + scoreboard for dut ----------------
    typedef struct { int due; logic [31:0] addr; } mreq_t;
    mreq_t       mq[$];
    logic [63:0] sb[$];
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt = 0;

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst) begin
            sb.delete();
        end else begin
            if (redirect_valid) sb.delete();
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{due: cyc + lat, addr: imem_req_addr});
                sb.push_back({imem_req_addr, mem_data(imem_req_addr)});
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: got pc %h expected no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", out_pc, e[63:32]);
                    check("sb_instr", out_instr, e[31:0]);
                end
            end
            if (imem_rsp_valid && !redirect_valid && dut.r_drop_cnt == 8'd0)
                check("buf_overflow", {31'b0, 32'(dut.w_buf_cnt) >= DEPTH}, 32'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // ---------------- 1-cycle memory for dut2 ----------------
    logic        f2 = 1'b0;
    logic [31:0] a2 = '0;
    logic [31:0] acc2[$];

    always @(negedge clk) begin
        f2 = !rst && req2_valid;
        a2 = req2_addr;
        if (f2) acc2.push_back(req2_addr);
    end

    always @(posedge clk) begin
        #1;
        rsp2_valid = f2 && !rst;
        rsp2_data  = mem_data(a2);
    end

    // ---------------- helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int new_lat);
        rst            = 1'b1;
        lat            = new_lat;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Returns at the negedge of the first cycle with out_valid high.
    task automatic wait_out(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no out_valid expected out_valid within 20 cycles", name);
        end
    endtask

    typedef struct { logic [31:0] target; logic [31:0] exp_addr; } rdr_vec_t;
    rdr_vec_t    rdr_tbl[4];
    logic [31:0] wrap_tbl[4];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;

        rdr_tbl[0] = '{target: 32'h0000_0203, exp_addr: 32'h0000_0200};
        rdr_tbl[1] = '{target: 32'h0000_0100, exp_addr: 32'h0000_0100};
        rdr_tbl[2] = '{target: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC};
        rdr_tbl[3] = '{target: 32'h0000_1006, exp_addr: 32'h0000_1004};
        wrap_tbl[0] = 32'hFFFF_FFF8;
        wrap_tbl[1] = 32'hFFFF_FFFC;
        wrap_tbl[2] = 32'h0000_0000;
        wrap_tbl[3] = 32'h0000_0004;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rsp2_valid     = 1'b0;
        rsp2_data      = '0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_req_addr2", req2_addr, 32'hFFFF_FFF8);
        @(posedge clk);
        #1 rst = 1'b0;

        // Streaming with 1-cycle memory
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("stream_req_valid", {31'b0, imem_req_valid}, 1);
            check("stream_req_addr", imem_req_addr, 32'(4 * i));
            if (i >= 2) begin
                check("stream_out_valid", {31'b0, out_valid}, 1);
                check("stream_out_pc", out_pc, 32'(4 * (i - 2)));
            end
            next_cycle();
        end

        // Wrap from the reset vector near the top of memory (DEPTH=2 instance)
        if (acc2.size() < 4) begin
            checks++; errors++;
            $display("FAIL wrap_count: got %0d requests expected at least 4", acc2.size());
        end else begin
            for (int i = 0; i < 4; i++) check("wrap_addr", acc2[i], wrap_tbl[i]);
        end

        // Decode stalls: capacity bound holds, then delivery resumes in order
        out_ready = 1'b0;
        a0 = acc_cnt;
        repeat (9) next_cycle();
        @(negedge clk);
        check("stall_req_valid", {31'b0, imem_req_valid}, 0);
        check("stall_out_valid", {31'b0, out_valid}, 1);
        next_cycle();
        out_ready = 1'b1;
        check("stall_accepts", {31'b0, (acc_cnt - a0) <= DEPTH}, 1);
        repeat (10) next_cycle();

        // Redirect with two requests in flight, 3-cycle memory
        do_reset(3);
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        check("rdr3_req_valid", {31'b0, imem_req_valid}, 0);
        check("rdr3_out_valid", {31'b0, out_valid}, 0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rdr3_next_valid", {31'b0, imem_req_valid}, 1);
        check("rdr3_next_addr", imem_req_addr, 32'h0000_0100);
        wait_out("rdr3");
        check("rdr3_first_pc", out_pc, 32'h0000_0100);

        // Redirects colliding with a response and a pending pop
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            repeat (3) next_cycle();
            redirect_valid = 1'b1;
            redirect_pc    = rdr_tbl[i].target;
            @(negedge clk);
            check("rdr_rsp_present", {31'b0, imem_rsp_valid}, 1);
            check("rdr_out_valid", {31'b0, out_valid}, 0);
            check("rdr_req_valid", {31'b0, imem_req_valid}, 0);
            next_cycle();
            redirect_valid = 1'b0;
            @(negedge clk);
            check("rdr_next_valid", {31'b0, imem_req_valid}, 1);
            check("rdr_next_addr", imem_req_addr, rdr_tbl[i].exp_addr);
            wait_out("rdr");
            check("rdr_first_pc", out_pc, rdr_tbl[i].exp_addr);
        end

        // Asynchronous reset with a full buffer
        next_cycle();
        out_ready = 1'b0;
        repeat (10) next_cycle();
        check("full_out_valid", {31'b0, out_valid}, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 0);
        check("arst_req_valid", {31'b0, imem_req_valid}, 0);
        check("arst_out_pc", out_pc, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("arst_restart_valid", {31'b0, imem_req_valid}, 1);
        check("arst_restart_addr", imem_req_addr, 32'h0);
        wait_out("arst");
        check("arst_first_pc", out_pc, 32'h0);
        repeat (4) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
